// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-side constants and timeout FSM state encoding.
package uart_pkg;
    localparam int DBIT_DEF     = 8;
    localparam int TO_CHARS     = 4;
    localparam int FRAME_BITS   = 10;
    localparam int OVERSAMPLE   = 16;
    localparam int TO_TICKS_DEF = TO_CHARS * FRAME_BITS * OVERSAMPLE;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        COUNT   = 2'b01,
        TIMEOUT = 2'b10
    } to_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers and flush.
module uart_sync_fifo #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [DBIT-1:0]            i_data,
    output logic [DBIT-1:0]            o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DBIT-1:0] r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_empty;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(i_push);
            r_rd_ptr <= r_rd_ptr + (AW+1)'(i_pop);
        end
    end

    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign o_valid = ~w_empty;
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) & (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    // Empty head reads as zero so the output is defined out of reset.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive FIFO controller with overrun, level and character-timeout irqs.
// Define UART_RX_TIMEOUT_EN to build the timeout FSM; otherwise irq_timeout is 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int DEPTH    = 16,
    parameter int THRESH   = 8,
    parameter int TO_TICKS = TO_TICKS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_en,
    input  logic                   baud_tick,
    input  logic                   rx_done,
    input  logic [DBIT-1:0]        rx_data,
    input  logic                   flush,
    input  logic                   rd_en,
    output logic [DBIT-1:0]        rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    input  logic                   ovr_clr,
    output logic                   irq_level,
    output logic                   irq_timeout
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] THR = LW'(THRESH);

    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic r_overrun;
    logic r_irq_level;

    assign w_push_req = rx_done & rx_en & ~flush;
    assign w_pop      = rd_en & rd_valid & ~flush;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign w_push     = w_push_req & (~full | w_pop);
    assign w_drop     = w_push_req & full & ~w_pop;

    uart_sync_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (rx_data),
        .o_data  (rd_data),
        .o_valid (rd_valid),
        .o_full  (full),
        .o_level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_irq_level <= 1'b0;
        end else begin
            r_overrun   <= w_drop | (r_overrun & ~ovr_clr);
            r_irq_level <= level >= THR;
        end
    end

    assign overrun   = r_overrun;
    assign irq_level = r_irq_level;

`ifdef UART_RX_TIMEOUT_EN
    localparam int CW = $clog2(TO_TICKS) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_TICKS - 1);

    to_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_irq_timeout;
    logic          w_emptying;

    assign w_emptying = w_pop & ~w_push & (level == LW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= EMPTY;
            r_cnt         <= '0;
            r_irq_timeout <= 1'b0;
        end else if (flush) begin
            r_state       <= EMPTY;
            r_cnt         <= '0;
            r_irq_timeout <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_cnt   <= '0;
                    r_state <= w_push ? COUNT : EMPTY;
                end
                COUNT: begin
                    if (w_push | w_pop) begin
                        r_cnt   <= '0;
                        r_state <= w_emptying ? EMPTY : COUNT;
                    end else if (baud_tick) begin
                        if (r_cnt == TO_LAST) begin
                            r_state       <= TIMEOUT;
                            r_irq_timeout <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                TIMEOUT: begin
                    if (w_push | w_pop) begin
                        r_cnt         <= '0;
                        r_irq_timeout <= 1'b0;
                        r_state       <= w_emptying ? EMPTY : COUNT;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign irq_timeout = r_irq_timeout;
`else
    logic w_unused_tick;
    assign w_unused_tick = baud_tick | (TO_TICKS == 0);
    assign irq_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl (DEPTH=16, THRESH=8).
module tb_uart_rx_ctrl;
    logic       clk = 0;
    logic       rst = 0;
    logic       rx_en = 0;
    logic       baud_tick = 0;
    logic       rx_done = 0;
    logic [7:0] rx_data = 0;
    logic       flush = 0;
    logic       rd_en = 0;
    logic       ovr_clr = 0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       irq_level;
    logic       irq_timeout;

    int vec = 0;
    int err = 0;

    uart_rx_ctrl #(.DBIT(8), .DEPTH(16), .THRESH(8), .TO_TICKS(640)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .baud_tick   (baud_tick),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .flush       (flush),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .level       (level),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .irq_level   (irq_level),
        .irq_timeout (irq_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_en = 1; rx_done = 1; rx_data = b;
        tick();
        rx_done = 0;
    endtask

    task automatic pop_check(input string nm, input logic [7:0] exp);
        vec++; if (rd_data !== exp || rd_valid !== 1'b1) begin err++; $display("FAIL %s: rd_data=%h valid=%b want %h valid=1", nm, rd_data, rd_valid, exp); end
        rd_en = 1;
        tick();
        rd_en = 0;
    endtask

    task automatic ticks(input int n);
        baud_tick = 1;
        repeat (n) tick();
        baud_tick = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        vec++; if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin err++; $display("FAIL reset_fifo: level=%0d valid=%b full=%b want 0/0/0", level, rd_valid, full); end
        vec++; if (overrun !== 1'b0 || irq_level !== 1'b0 || irq_timeout !== 1'b0) begin err++; $display("FAIL reset_flags: ovr=%b irql=%b irqt=%b want 0/0/0", overrun, irq_level, irq_timeout); end
        vec++; if (rd_data !== 8'h00) begin err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        push(8'h11); push(8'h22); push(8'h33);
        vec++; if (level !== 5'd3) begin err++; $display("FAIL basic_level3: got %0d want 3", level); end
        pop_check("basic_pop0", 8'h11);
        pop_check("basic_pop1", 8'h22);
        pop_check("basic_pop2", 8'h33);
        vec++; if (level !== 5'd0 || rd_valid !== 1'b0) begin err++; $display("FAIL basic_empty: level=%0d valid=%b want 0/0", level, rd_valid); end
        rd_en = 1; tick(); rd_en = 0;
        vec++; if (level !== 5'd0) begin err++; $display("FAIL pop_empty_ignored: level=%0d want 0", level); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) begin
            push(8'h40 + 8'(i));
            if (i == 14) begin vec++; if (full !== 1'b0) begin err++; $display("FAIL full_early: full=%b want 0 at level 15", full); end end
        end
        vec++; if (full !== 1'b1 || level !== 5'd16) begin err++; $display("FAIL full_after16: full=%b level=%0d want 1/16", full, level); end
        rx_done = 1; rx_data = 8'hAA; rd_en = 1;
        tick();
        rx_done = 0; rd_en = 0;
        vec++; if (level !== 5'd16 || overrun !== 1'b0) begin err++; $display("FAIL full_pushpop: level=%0d ovr=%b want 16/0", level, overrun); end
        rx_done = 1; rx_data = 8'hEE; ovr_clr = 1;
        tick();
        rx_done = 0; ovr_clr = 0;
        vec++; if (overrun !== 1'b1 || level !== 5'd16) begin err++; $display("FAIL overrun_set_wins: ovr=%b level=%0d want 1/16", overrun, level); end
        for (int i = 1; i < 16; i++) pop_check("drain_full", 8'h40 + 8'(i));
        pop_check("drain_last_aa", 8'hAA);
        vec++; if (rd_valid !== 1'b0 || overrun !== 1'b1) begin err++; $display("FAIL drained: valid=%b ovr=%b want 0/1", rd_valid, overrun); end
        ovr_clr = 1; tick(); ovr_clr = 0;
        vec++; if (overrun !== 1'b0) begin err++; $display("FAIL ovr_clr: ovr=%b want 0", overrun); end
    endtask

    task automatic test_irq_level();
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        tick();
        vec++; if (irq_level !== 1'b0) begin err++; $display("FAIL irql_below: irq=%b want 0 at level 7", irq_level); end
        push(8'h87);
        vec++; if (irq_level !== 1'b0 || level !== 5'd8) begin err++; $display("FAIL irql_registered: irq=%b level=%0d want 0/8", irq_level, level); end
        tick();
        vec++; if (irq_level !== 1'b1) begin err++; $display("FAIL irql_rise: irq=%b want 1", irq_level); end
        pop_check("irql_pop", 8'h80);
        vec++; if (irq_level !== 1'b1) begin err++; $display("FAIL irql_hold: irq=%b want 1 same cycle as pop", irq_level); end
        tick();
        vec++; if (irq_level !== 1'b0) begin err++; $display("FAIL irql_fall: irq=%b want 0", irq_level); end
        for (int i = 1; i < 8; i++) pop_check("irql_drain", 8'h80 + 8'(i));
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
        for (int i = 0; i < 11; i++) pop_check("flush_prep", 8'hC0 + 8'(i));
        vec++; if (level !== 5'd5 || overrun !== 1'b1) begin err++; $display("FAIL flush_prep: level=%0d ovr=%b want 5/1", level, overrun); end
        flush = 1; rx_done = 1; rx_data = 8'h55; rd_en = 1;
        tick();
        flush = 0; rx_done = 0; rd_en = 0;
        vec++; if (level !== 5'd0 || rd_valid !== 1'b0 || overrun !== 1'b1) begin err++; $display("FAIL flush: level=%0d valid=%b ovr=%b want 0/0/1", level, rd_valid, overrun); end
        push(8'h66);
        pop_check("flush_no55", 8'h66);
        ovr_clr = 1; tick(); ovr_clr = 0;
    endtask

    task automatic test_rx_disabled();
        rx_en = 0; rx_done = 1; rx_data = 8'h77;
        tick();
        rx_done = 0;
        vec++; if (level !== 5'd0 || overrun !== 1'b0) begin err++; $display("FAIL rx_disabled: level=%0d ovr=%b want 0/0", level, overrun); end
        rx_en = 1;
    endtask

    task automatic test_empty_pushpop();
        rx_done = 1; rx_data = 8'h5A; rd_en = 1;
        tick();
        rx_done = 0; rd_en = 0;
        vec++; if (level !== 5'd1) begin err++; $display("FAIL empty_pushpop: level=%0d want 1", level); end
        pop_check("empty_pushpop_data", 8'h5A);
    endtask

    task automatic test_async_reset();
        push(8'h01); push(8'h02);
        @(negedge clk);
        rst = 1;
        #1;
        vec++; if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin err++; $display("FAIL async_reset: level=%0d valid=%b data=%h want 0/0/00", level, rd_valid, rd_data); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_timeout();
`ifdef UART_RX_TIMEOUT_EN
        push(8'h91);
        ticks(639);
        vec++; if (irq_timeout !== 1'b0) begin err++; $display("FAIL to_early: irq=%b want 0 after 639 ticks", irq_timeout); end
        ticks(1);
        vec++; if (irq_timeout !== 1'b1) begin err++; $display("FAIL to_fire: irq=%b want 1 after 640 ticks", irq_timeout); end
        pop_check("to_pop", 8'h91);
        vec++; if (irq_timeout !== 1'b0) begin err++; $display("FAIL to_clear: irq=%b want 0", irq_timeout); end
        ticks(700);
        vec++; if (irq_timeout !== 1'b0) begin err++; $display("FAIL to_empty_idle: irq=%b want 0", irq_timeout); end
        push(8'h92);
        ticks(300);
        push(8'h93);
        ticks(639);
        vec++; if (irq_timeout !== 1'b0) begin err++; $display("FAIL to_restart: irq=%b want 0 at 639 after push", irq_timeout); end
        ticks(1);
        vec++; if (irq_timeout !== 1'b1) begin err++; $display("FAIL to_restart_fire: irq=%b want 1", irq_timeout); end
        pop_check("to_pop2", 8'h92);
        ticks(640);
        vec++; if (irq_timeout !== 1'b1) begin err++; $display("FAIL to_refire: irq=%b want 1", irq_timeout); end
        pop_check("to_pop3", 8'h93);
`else
        push(8'h91);
        ticks(700);
        vec++; if (irq_timeout !== 1'b0) begin err++; $display("FAIL to_disabled: irq=%b want 0", irq_timeout); end
        pop_check("to_disabled_pop", 8'h91);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_irq_level();
        test_flush();
        test_rx_disabled();
        test_empty_pushpop();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
